// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants and types for the VGA pixel-interface source.
//  - DEF_* : 640x480@60 (25 MHz pixel clock) line/frame timing.
//  - DEF_H_TOTAL / DEF_V_TOTAL : full line / frame lengths derived from above.
//  - coord_t : pixel coordinate type for DrawX/DrawY (10 bits, up to 1023).
//  - sync_t  : {hs, vs} pair carried through the sync delay line.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int COORD_W   = 10;
  localparam int COORD_MAX = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic hs;
    logic vs;
  } sync_t;

  // Narrow an elaboration-time integer to a coordinate constant.
  function automatic coord_t to_coord(input int v);
    return coord_t'(v);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// ---------------------------------------------------------------------------
// vga_sync_delay
// DEPTH-stage shift register for the {hs, vs} pair so the syncs line up with
// RGB coming out of the registered renderers. DEPTH=0 is a wire.
// Ports:
//  clk_i   in  pixel clock
//  rst_ni  in  synchronous reset, active-low; every stage loads INIT
//  d_i     in  raw {hs, vs}
//  q_o     out {hs, vs} delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int    DEPTH = 1,
  parameter sync_t INIT  = '{hs: 1'b1, vs: 1'b1}
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  sync_t d_i,
  output sync_t q_o
);

  if (DEPTH == 0) begin : g_pass
    // Clock/reset have nothing to drive here.
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign q_o = d_i;
  end else begin : g_sr
    sync_t [DEPTH-1:0] sr_q;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        for (int i = 0; i < DEPTH; i++) sr_q[i] <= INIT;
      end else begin
        sr_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
    end

    assign q_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Pixel-interface source: free-running line/frame counters, visible-region
// flag, hs/vs aligned to the renderers' one-cycle RGB latency, and a
// once-per-frame strobe plus frame counter for game logic.
// Ports:
//  vga_clk      in   pixel clock
//  reset_n      in   synchronous reset, active-low
//  hs, vs       out  syncs, delayed PIPE_DELAY cycles from the counters
//  blank        out  1 = DrawX/DrawY inside the visible region
//  DrawX/DrawY  out  raw horizontal / vertical counters (zero latency)
//  frame_done   out  one-cycle strobe at (0, V_ACTIVE), start of vblank
//  frame_count  out  frames completed since reset, wraps at 256
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   H_FP       = DEF_H_FP,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BP       = DEF_H_BP,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   V_FP       = DEF_V_FP,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BP       = DEF_V_BP,
  parameter logic SYNC_ACT   = 1'b0,
  parameter int   PIPE_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output coord_t     DrawX,
  output coord_t     DrawY,
  output logic       frame_done,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam bit CFG_OK = (H_TOTAL <= COORD_MAX) && (V_TOTAL <= COORD_MAX) &&
                          (PIPE_DELAY >= 0) && (PIPE_DELAY <= 4) &&
                          (H_ACTIVE >= 1) && (H_FP >= 1) && (H_SYNC >= 1) && (H_BP >= 1) &&
                          (V_ACTIVE >= 1) && (V_FP >= 1) && (V_SYNC >= 1) && (V_BP >= 1);

  if (!CFG_OK) begin : g_cfg_bad
    $fatal(1, "vga_timing_gen: illegal timing parameters");
  end

  // Decode constants, all in counter width.
  localparam coord_t H_LAST     = to_coord(H_TOTAL - 1);
  localparam coord_t V_LAST     = to_coord(V_TOTAL - 1);
  localparam coord_t H_VIS      = to_coord(H_ACTIVE);
  localparam coord_t V_VIS      = to_coord(V_ACTIVE);
  localparam coord_t V_VIS_LAST = to_coord(V_ACTIVE - 1);
  localparam coord_t HS_FIRST   = to_coord(H_ACTIVE + H_FP);
  localparam coord_t HS_LAST    = to_coord(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST   = to_coord(V_ACTIVE + V_FP);
  localparam coord_t VS_LAST    = to_coord(V_ACTIVE + V_FP + V_SYNC - 1);

  coord_t     hc_q, hc_d;
  coord_t     vc_q, vc_d;
  logic       frame_done_q, frame_done_d;
  logic [7:0] frame_count_q, frame_count_d;
  sync_t      sync_raw, sync_dly;

  // Counters free-run: no enable, no stall.
  always_comb begin
    hc_d = hc_q + 1'b1;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
    end
  end

  // The strobe is registered off the last pixel of the last visible line, so
  // it lands on the first cycle of vertical blanking (hc=0, vc=V_ACTIVE).
  always_comb begin
    frame_done_d  = (hc_q == H_LAST) && (vc_q == V_VIS_LAST);
    frame_count_d = frame_done_d ? frame_count_q + 8'd1 : frame_count_q;
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hc_q          <= '0;
      vc_q          <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Raw sync decode off the registered counters; vs covers whole lines.
  always_comb begin
    sync_raw.hs = ((hc_q >= HS_FIRST) && (hc_q <= HS_LAST)) ? SYNC_ACT : ~SYNC_ACT;
    sync_raw.vs = ((vc_q >= VS_FIRST) && (vc_q <= VS_LAST)) ? SYNC_ACT : ~SYNC_ACT;
  end

  vga_sync_delay #(
    .DEPTH (PIPE_DELAY),
    .INIT  (sync_t'({~SYNC_ACT, ~SYNC_ACT}))
  ) u_sync_dly (
    .clk_i  (vga_clk),
    .rst_ni (reset_n),
    .d_i    (sync_raw),
    .q_o    (sync_dly)
  );

  assign hs          = sync_dly.hs;
  assign vs          = sync_dly.vs;
  assign blank       = (hc_q < H_VIS) && (vc_q < V_VIS);
  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule
